// File: rtl/mdu_unit_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide unit.
//   start   : qualifies mdu_op this cycle
//   mdu_op  : operation code (NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO)
//   a, b    : rs / rt operand values
//   busy    : a multiply or divide is in flight
//   hi, lo  : architectural HI/LO registers
//   rd_data : combinational MFHI/MFLO read value
// master drives the request side (EX stage); slave is the unit itself.
interface mdu_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       mdu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output start, mdu_op, a, b,
        input  busy, hi, lo, rd_data
    );

    modport slave (
        input  start, mdu_op, a, b,
        output busy, hi, lo, rd_data
    );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears busy, counter, HI/LO and latched operands
//   bus   : mdu_unit_if slave port (start, mdu_op, a, b in; busy, hi, lo, rd_data out)
// mult/multu occupy MULT_CYCLES cycles, div/divu occupy DIV_CYCLES cycles; the result is
// computed from the operands latched at acceptance and written to HI/LO on completion.
module mdu_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    mdu_unit_if.slave  bus
);
    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMfhi  = 4'd5;
    localparam logic [3:0] OpMflo  = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;

    logic                 is_md, is_mult, load_md, div_by_zero;
    logic [2*WIDTH-1:0]   a_sx, b_sx, prod_s, prod_u;
    logic [WIDTH-1:0]     sdiv_b, udiv_b, sdiv_q, sdiv_r, udiv_q, udiv_r;
    logic [WIDTH-1:0]     res_hi, res_lo;

    assign is_md   = (bus.mdu_op >= OpMult) && (bus.mdu_op <= OpDivu);
    assign is_mult = (bus.mdu_op == OpMult) || (bus.mdu_op == OpMultu);

    // Datapath works only on the latched operands.
    always_comb begin
        a_sx   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        b_sx   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        // Low 2*WIDTH bits of the sign-extended product are the signed product.
        prod_s = a_sx * b_sx;
        prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        // Most-negative / -1 is divided by 1 instead: quotient stays most-negative,
        // remainder 0. A zero divisor is also replaced so the datapath never sees it.
        if ((b_q == '0) || ((a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1))) begin
            sdiv_b = WIDTH'(1);
        end else begin
            sdiv_b = b_q;
        end
        udiv_b = (b_q == '0) ? WIDTH'(1) : b_q;
        sdiv_q = $signed(a_q) / $signed(sdiv_b);
        sdiv_r = $signed(a_q) % $signed(sdiv_b);
        udiv_q = a_q / udiv_b;
        udiv_r = a_q % udiv_b;

        case (op_q)
            OpMult:  begin res_hi = prod_s[2*WIDTH-1:WIDTH]; res_lo = prod_s[WIDTH-1:0]; end
            OpMultu: begin res_hi = prod_u[2*WIDTH-1:WIDTH]; res_lo = prod_u[WIDTH-1:0]; end
            OpDiv:   begin res_hi = sdiv_r; res_lo = sdiv_q; end
            default: begin res_hi = udiv_r; res_lo = udiv_q; end
        endcase
        div_by_zero = ((op_q == OpDiv) || (op_q == OpDivu)) && (b_q == '0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load_md = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    case (bus.mdu_op)
                        OpMthi:  hi_d = bus.a;
                        OpMtlo:  lo_d = bus.a;
                        default: load_md = is_md;
                    endcase
                end
            end
            StBusy: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    if (!div_by_zero) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                    // The completing edge frees the unit, so a following mult/div is
                    // taken back-to-back; moves to HI/LO still wait for busy low.
                    load_md = bus.start && is_md;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_md) begin
            op_d    = bus.mdu_op;
            a_d     = bus.a;
            b_d     = bus.b;
            state_d = StBusy;
            cnt_d   = is_mult ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy    = (state_q == StBusy);
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.rd_data = (bus.mdu_op == OpMfhi) ? hi_q :
                         (bus.mdu_op == OpMflo) ? lo_q : '0;
endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: the stimulus side computes expected HI/LO with plain
// 64-bit arithmetic and queues them; a monitor counts busy cycles and compares HI/LO
// one sample after each operation's final busy cycle.
module tb_mdu_unit;
    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    mdu_unit_if #(.WIDTH(32)) bus ();

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one op for one cycle and update the reference model as the spec dictates.
    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        exp_t        e;
        logic [63:0] p;
        longint      q, r;
        logic [31:0] rd_exp;
        rd_exp = (op == 4'd5) ? ref_hi : (op == 4'd6) ? ref_lo : 32'h0;
        bus.start  = 1'b1;
        bus.mdu_op = op;
        bus.a      = av;
        bus.b      = bv;
        #1;
        check("rd_data", bus.rd_data, rd_exp);
        e.hi = ref_hi;
        e.lo = ref_lo;
        e.n  = 0;
        case (op)
            4'd1: begin
                p = 64'(longint'($signed(av)) * longint'($signed(bv)));
                e.hi = p[63:32]; e.lo = p[31:0]; e.n = MC;
            end
            4'd2: begin
                p = {32'h0, av} * {32'h0, bv};
                e.hi = p[63:32]; e.lo = p[31:0]; e.n = MC;
            end
            4'd3, 4'd4: begin
                e.n = DC;
                if (bv != 32'h0) begin
                    if (op == 4'd3) begin
                        q = longint'($signed(av)) / longint'($signed(bv));
                        r = longint'($signed(av)) % longint'($signed(bv));
                    end else begin
                        q = longint'({32'h0, av}) / longint'({32'h0, bv});
                        r = longint'({32'h0, av}) % longint'({32'h0, bv});
                    end
                    e.hi = r[31:0];
                    e.lo = q[31:0];
                end
            end
            4'd7: ref_hi = av;
            4'd8: ref_lo = av;
            default: ;
        endcase
        if (e.n != 0) begin
            ref_hi = e.hi;
            ref_lo = e.lo;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.mdu_op = 4'd0;
        bus.a      = $urandom;
        bus.b      = $urandom;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200; i++) begin
            if (!bus.busy) break;
            @(posedge clk); #1;
        end
        if (i == 200) begin
            checks++;
            errors++;
            $display("FAIL wait_idle actual=busy required=idle within 200 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_busy"}, {31'h0, bus.busy}, 32'h0);
        check({tag, "_hi"}, bus.hi, ref_hi);
        check({tag, "_lo"}, bus.lo, ref_lo);
    endtask

    // Monitor: HI/LO are compared one sample after the Nth busy cycle of each op.
    initial begin : monitor
        exp_t e;
        int   cyc;
        logic pending;
        logic prev_busy;
        cyc = 0; pending = 1'b0; prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cyc = 0; pending = 1'b0; prev_busy = 1'b0;
            end else begin
                if (pending) begin
                    e = exp_q.pop_front();
                    pending = 1'b0;
                    check("sb_hi", bus.hi, e.hi);
                    check("sb_lo", bus.lo, e.lo);
                    check("sb_busy_end", {31'h0, bus.busy}, {31'h0, exp_q.size() != 0});
                end else if (prev_busy && !bus.busy) begin
                    checks++;
                    errors++;
                    $display("FAIL busy_len actual=%0d required=%0d", cyc,
                             (exp_q.size() != 0) ? exp_q[0].n : 0);
                    cyc = 0;
                end
                if (bus.busy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_busy actual=1 required=0");
                    end else begin
                        cyc++;
                        if (cyc == exp_q[0].n) begin
                            pending = 1'b1;
                            cyc = 0;
                        end
                    end
                end
                prev_busy = bus.busy;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [3:0]  op;
        logic [31:0] av, bv;
        bus.start  = 1'b0;
        bus.mdu_op = 4'd0;
        bus.a      = '0;
        bus.b      = '0;
        #12;
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Signed and unsigned multiply of -3 x 5.
        issue(4'd1, 32'hFFFF_FFFD, 32'd5); wait_idle(); check_regs("mult");
        check("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo_const", bus.lo, 32'hFFFF_FFF1);
        issue(4'd2, 32'hFFFF_FFFD, 32'd5); wait_idle(); check_regs("multu");
        check("multu_hi_const", bus.hi, 32'h0000_0004);

        // Division, including the signed overflow case.
        issue(4'd3, 32'hFFFF_FFF9, 32'd2); wait_idle(); check_regs("div");
        check("div_lo_const", bus.lo, 32'hFFFF_FFFD);
        check("div_hi_const", bus.hi, 32'hFFFF_FFFF);
        issue(4'd4, 32'd7, 32'd2); wait_idle(); check_regs("divu");
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle(); check_regs("div_ovf");
        check("div_ovf_lo_const", bus.lo, 32'h8000_0000);

        // Moves to/from HI/LO on consecutive cycles.
        issue(4'd7, 32'h1234_5678, 32'h0);
        issue(4'd8, 32'h9ABC_DEF0, 32'h0);
        check_regs("mt");
        issue(4'd5, 32'h0, 32'h0);
        issue(4'd6, 32'h0, 32'h0);
        check("mfhi_const", ref_hi, 32'h1234_5678);

        // Divide by zero leaves HI/LO; MTLO while busy is ignored.
        issue(4'd7, 32'h11, 32'h0);
        issue(4'd8, 32'h22, 32'h0);
        issue(4'd4, 32'd5, 32'd0); wait_idle(); check_regs("div0");
        check("div0_lo_const", bus.lo, 32'h22);
        issue(4'd1, 32'd2, 32'd3);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mdu_op = 4'd8; bus.a = 32'hFFFF;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mdu_op = 4'd0;
        wait_idle(); check_regs("mtlo_busy");
        check("mtlo_busy_lo_const", bus.lo, 32'd6);

        // Back-to-back multiplies: second driven during the last busy cycle of the first.
        issue(4'd1, 32'd3, 32'd4);
        repeat (MC - 1) begin @(posedge clk); #1; end
        issue(4'd1, 32'd5, 32'd6);
        wait_idle(); check_regs("b2b");
        check("b2b_lo_const", bus.lo, 32'd30);

        // Asynchronous reset in the fourth busy cycle of a divide.
        issue(4'd7, 32'hAAAA, 32'h0);
        issue(4'd3, 32'd100, 32'd7);
        repeat (3) begin @(posedge clk); #1; end
        #2;
        reset = 1'b1;
        exp_q.delete();
        ref_hi = '0;
        ref_lo = '0;
        #1;
        check("arst_busy", {31'h0, bus.busy}, 32'h0);
        check("arst_hi", bus.hi, 32'h0);
        check("arst_lo", bus.lo, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        check_regs("post_rst");

        // Randomized ops with biased corner operands.
        for (int k = 0; k < 60; k++) begin
            op = 4'($urandom_range(0, 15));
            av = $urandom;
            bv = $urandom;
            case ($urandom_range(0, 7))
                0: bv = 32'h0;
                1: begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
                2: bv = 32'($urandom_range(1, 9));
                3: av = 32'($urandom_range(0, 20)) - 32'd10;
                default: ;
            endcase
            issue(op, av, bv);
            wait_idle();
            check_regs("rand");
        end

        check("queue_drain", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
